handshake_rr_arbiter: RTL and testbench
=======================================

Name: handshake_rr_arbiter

Overview:
- Round-robin arbiter merging N valid/ready requester streams onto one downstream valid/ready channel.
- Sits between multiple Handshake_Sender-style masters and a single bridge/receiver chain (Type2/Type3 slices, Handshake_Receiver).
- Output is a registered full-throughput pipeline stage: 1 beat/cycle, 1-cycle latency.
- Configurable burst lock keeps a grant on one requester for up to MAX_BURST consecutive beats.

Parameters:
- N, 4, number of requesters (2..16).
- DATA_W, 8, payload width.
- ID_W, $clog2(N), width of the source-id field.
- MAX_BURST, 2, maximum consecutive beats per grant (>=1; 1 = pure round-robin).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_pre_i  in  N  per-requester valid.
- data_pre_i  in  N*DATA_W  per-requester payload; requester k at bits [k*DATA_W +: DATA_W].
- ready_pre_o  out  N  per-requester ready, one-hot or zero.
- valid_post_o  out  1  downstream valid (registered).
- data_post_o  out  DATA_W  downstream payload (registered).
- id_post_o  out  ID_W  index of the requester that sourced the beat (registered).
- ready_post_i  in  1  downstream ready.

Behaviour:
- Reset (async, rst=1): valid_post_o=0, data_post_o=0, id_post_o=0, holder=0, burst_cnt=0, rr_ptr=0. ready_pre_o=0 while rst=1.
- load_en = !valid_post_o || ready_post_i.
  - When load_en=0, all ready_pre_o=0 and the output registers hold.
- Winner selection (combinational, only when load_en=1 and |valid_pre_i):
  - Lock condition: burst_cnt!=0 && valid_pre_i[holder] && burst_cnt<MAX_BURST. When true, winner=holder.
  - Otherwise, winner is the first k with valid_pre_i[k]=1, scanning rr_ptr, rr_ptr+1, ... mod N.
- ready_pre_o[winner]=1 and all other bits are 0. Transfer from requester k occurs when valid_pre_i[k] && ready_pre_o[k].
- On transfer:
  - data_post_o<=data_pre_i[winner], id_post_o<=winner, valid_post_o<=1.
  - If lock was active: burst_cnt<=burst_cnt+1. Otherwise: holder<=winner, burst_cnt<=1.
  - rr_ptr<=(winner+1) mod N.
- load_en=1 with no requester valid: valid_post_o<=0. data/id hold their last values. burst_cnt<=0, which releases the lock.
- When burst_cnt reaches MAX_BURST, the lock releases. The next grant is round-robin from holder+1. The same requester may win again only if no other requester is valid.
- If the holder drops valid mid-burst, the lock releases immediately and round-robin selection resumes from holder+1.
- While valid_post_o=1 && ready_post_i=0, data_post_o/id_post_o are stable. No beat is lost or duplicated.
- ready_pre_o depends combinationally on valid_pre_i, ready_post_i and state. valid_post_o, data_post_o and id_post_o have no combinational path from inputs.
- Requesters obey the standard rule: once valid is asserted, payload holds until accepted. The arbiter does not rely on it for correctness of the beat it samples.
- Reset mid-operation: an in-flight output beat is dropped, and the round-robin state returns to requester 0 priority.

Test Plan:
- Reset: drive traffic, assert rst for 2 cycles mid-stream -> valid_post_o=0, id_post_o=0, ready_pre_o=0 during rst. The first grant after release goes to the lowest-index valid requester.
- Full contention: N=4, MAX_BURST=2, all valid, ready_post_i=1 -> id_post_o sequence 0,0,1,1,2,2,3,3,0,0. One beat per cycle after 1-cycle latency.
- Single requester: only requester 2 valid, data 1..10 -> id_post_o=2 every cycle, data 1..10 in order, no bubble at burst boundaries.
- Backpressure: ready_post_i=0 for 3 cycles while valid_post_o=1 with data=0x35 -> data_post_o=0x35 stable, ready_pre_o=0. On ready_post_i=1 the next beat follows with no gap or duplicate.
- Holder drop: requester 1 granted one beat then deasserts valid, requesters 0 and 3 valid -> next grant is 3 (scan from 2), then 0.
- Random soak: $random per-requester valid and downstream ready. Each requester sends incrementing data starting at 1. A per-id scoreboard checks in-order, lossless, duplicate-free delivery of 200 beats per requester. Also check that no valid requester waits longer than (N-1)*MAX_BURST accepted beats.

Source files
------------

// File: rtl/handshake_rr_arbiter.sv
// Round-robin merge of N valid/ready streams onto one registered channel,
// with an optional burst lock that keeps a grant for up to MAX_BURST beats.
module handshake_rr_arbiter #(
  parameter int N         = 4,
  parameter int DATA_W    = 8,
  parameter int ID_W      = $clog2(N),
  parameter int MAX_BURST = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        valid_pre_i,
  input  logic [N*DATA_W-1:0] data_pre_i,
  output logic [N-1:0]        ready_pre_o,
  output logic                valid_post_o,
  output logic [DATA_W-1:0]   data_post_o,
  output logic [ID_W-1:0]     id_post_o,
  input  logic                ready_post_i
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [ID_W:0]    N_EXT     = (ID_W+1)'(N);

  logic [ID_W-1:0]   holder;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  burst_cnt;

  logic              load_en;
  logic              any_valid;
  logic              lock;
  logic              xfer;
  logic [N-1:0]      rot;
  logic [ID_W-1:0]   off;
  logic [ID_W:0]     rr_sum;
  logic [ID_W-1:0]   rr_pick;
  logic [ID_W-1:0]   winner;
  logic [ID_W:0]     win_inc;
  logic [ID_W-1:0]   next_ptr;
  logic [DATA_W-1:0] win_data;

  assign load_en   = !valid_post_o || ready_post_i;
  assign any_valid = |valid_pre_i;
  assign xfer      = load_en && any_valid && !rst;

  assign lock = (burst_cnt != '0)
             && valid_pre_i[holder]
             && (burst_cnt < BURST_MAX);

  // rot[i] is the valid of requester (rr_ptr + i) mod N
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (ID_W'(j) == rr_ptr) begin
          rot[i] = valid_pre_i[(i + j) % N];
        end
      end
    end
  end

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = ID_W'(i);
      end
    end
  end

  assign rr_sum  = {1'b0, rr_ptr} + {1'b0, off};
  assign rr_pick = (rr_sum >= N_EXT) ? ID_W'(rr_sum - N_EXT)
                                     : ID_W'(rr_sum);

  assign winner  = lock ? holder : rr_pick;

  assign win_inc  = {1'b0, winner} + (ID_W+1)'(1);
  assign next_ptr = (win_inc == N_EXT) ? '0 : ID_W'(win_inc);

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (ID_W'(i) == winner) begin
        win_data = data_pre_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ready_pre_o = '0;
    if (xfer) begin
      ready_pre_o[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_post_o <= 1'b0;
      data_post_o  <= '0;
      id_post_o    <= '0;
      holder       <= '0;
      burst_cnt    <= '0;
      rr_ptr       <= '0;
    end else if (load_en) begin
      if (any_valid) begin
        valid_post_o <= 1'b1;
        data_post_o  <= win_data;
        id_post_o    <= winner;
        rr_ptr       <= next_ptr;
        if (lock) begin
          burst_cnt <= burst_cnt + CNT_W'(1);
        end else begin
          holder    <= winner;
          burst_cnt <= CNT_W'(1);
        end
      end else begin
        // an idle load slot also ends any burst in progress
        valid_post_o <= 1'b0;
        burst_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Bench for handshake_rr_arbiter: directed scenarios, a grant model
// compared every cycle, and a random soak with per-id scoreboard.
module tb_handshake_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int MB = 2;
  localparam int SOAK_BEATS = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  vld = '0;
  logic [N*DW-1:0] dat = '0;
  logic          rdy = 1'b1;
  logic [N-1:0]  ready_pre_o;
  logic          valid_post_o;
  logic [DW-1:0] data_post_o;
  logic [IW-1:0] id_post_o;

  handshake_rr_arbiter #(
    .N(N), .DATA_W(DW), .ID_W(IW), .MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid_pre_i(vld),
    .data_pre_i(dat),
    .ready_pre_o(ready_pre_o),
    .valid_post_o(valid_post_o),
    .data_post_o(data_post_o),
    .id_post_o(id_post_o),
    .ready_post_i(rdy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, got, exp, $time);
  endtask

  // ---- spec-level model: who owns the channel, streak length, next start
  bit          m_valid  = 1'b0;
  logic [7:0]  m_data   = '0;
  int          m_id     = 0;
  int          m_holder = 0;
  int          m_streak = 0;
  int          m_next   = 0;

  function automatic int pick(input logic [N-1:0] v);
    if (m_streak > 0 && m_streak < MB && v[m_holder])
      return m_holder;
    for (int i = 0; i < N; i++) begin
      if (v[(m_next + i) % N]) return (m_next + i) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_data = 0; m_id = 0;
      m_holder = 0; m_streak = 0; m_next = 0;
    end else if (!m_valid || rdy) begin
      int w;
      w = pick(vld);
      if (w < 0) begin
        m_valid  = 0;
        m_streak = 0;
      end else begin
        if (w == m_holder && m_streak > 0 && m_streak < MB)
          m_streak++;
        else begin
          m_holder = w;
          m_streak = 1;
        end
        m_next  = (w + 1) % N;
        m_valid = 1;
        m_data  = dat[w*DW +: DW];
        m_id    = w;
      end
    end
  end

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    if (rst || (m_valid && !rdy)) return r;
    w = pick(vld);
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  always @(negedge clk) begin
    chk("ready_pre", 32'(ready_pre_o), 32'(exp_ready()));
    chk("valid_post", 32'(valid_post_o), 32'(m_valid));
    if (m_valid) begin
      chk("data_post", 32'(data_post_o), 32'(m_data));
      chk("id_post", 32'(id_post_o), 32'(m_id));
    end
  end

  // ---- downstream monitor and soak scoreboard
  int cyc = 0;
  int log_id[$];
  int log_data[$];
  int log_cyc[$];
  bit soak_on = 1'b0;
  int exp_next[N];

  always @(posedge clk) begin
    cyc++;
    if (!rst && valid_post_o && rdy) begin
      log_id.push_back(int'(id_post_o));
      log_data.push_back(int'(data_post_o));
      log_cyc.push_back(cyc);
      if (soak_on) begin
        chk("soak_order", 32'(data_post_o),
            32'(exp_next[id_post_o]));
        exp_next[id_post_o]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_id.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic drain();
    vld = '0;
    rdy = 1'b1;
    repeat (3) tick();
  endtask

  task automatic send_one(input int k, input logic [7:0] d);
    bit acc;
    acc = 1'b0;
    vld[k] = 1'b1;
    dat[k*DW +: DW] = d;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      acc = ready_pre_o[k];
      @(posedge clk);
      #1;
    end
    vld[k] = 1'b0;
    chk("send_accept", 32'(acc), 32'd1);
  endtask

  int src[N];
  int waitc[N];
  int exp_ids[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

  initial begin
    // reset held with all requesters asking
    vld = '1;
    rdy = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(valid_post_o), 32'd0);
    chk("rst_id", 32'(id_post_o), 32'd0);
    chk("rst_data", 32'(data_post_o), 32'd0);
    chk("rst_ready", 32'(ready_pre_o), 32'd0);
    tick();
    tick();

    // full contention
    clear_log();
    rst = 1'b0;
    for (int k = 0; k < N; k++) dat[k*DW +: DW] = 8'(8'h10 + k);
    vld = '1;
    repeat (10) tick();
    vld = '0;
    repeat (3) tick();
    chk("cont_count", 32'(log_id.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < log_id.size()) begin
        chk("cont_id", 32'(log_id[i]), 32'(exp_ids[i]));
        chk("cont_data", 32'(log_data[i]), 32'(8'h10 + exp_ids[i]));
      end
    end
    if (log_cyc.size() == 10)
      chk("cont_rate", 32'(log_cyc[9] - log_cyc[0]), 32'd9);
    drain();

    // single requester streams through burst boundaries
    clear_log();
    for (int d = 1; d <= 10; d++) send_one(2, 8'(d));
    drain();
    chk("single_count", 32'(log_id.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < log_id.size()) begin
        chk("single_id", 32'(log_id[i]), 32'd2);
        chk("single_data", 32'(log_data[i]), 32'(i + 1));
      end
    end
    if (log_cyc.size() == 10)
      chk("single_rate", 32'(log_cyc[9] - log_cyc[0]), 32'd9);

    // backpressure
    clear_log();
    vld = 4'b0001;
    dat[0 +: DW] = 8'h35;
    tick();
    vld = 4'b0010;
    dat[DW +: DW] = 8'h36;
    rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", 32'(valid_post_o), 32'd1);
      chk("bp_data", 32'(data_post_o), 32'h35);
      chk("bp_ready", 32'(ready_pre_o), 32'd0);
      tick();
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(ready_pre_o), 32'b0010);
    tick();
    vld = '0;
    @(negedge clk);
    chk("bp_next", 32'(data_post_o), 32'h36);
    tick();
    tick();
    chk("bp_count", 32'(log_data.size()), 32'd2);
    if (log_data.size() == 2) begin
      chk("bp_first", 32'(log_data[0]), 32'h35);
      chk("bp_second", 32'(log_data[1]), 32'h36);
      chk("bp_gap", 32'(log_cyc[1] - log_cyc[0]), 32'd1);
    end
    drain();

    // holder drops after one beat
    clear_log();
    vld = 4'b0010;
    dat[DW +: DW] = 8'h41;
    tick();
    vld = 4'b1001;
    dat[0 +: DW] = 8'h50;
    dat[3*DW +: DW] = 8'h53;
    @(negedge clk);
    chk("drop_grant3", 32'(ready_pre_o), 32'b1000);
    tick();
    vld = 4'b0001;
    @(negedge clk);
    chk("drop_grant0", 32'(ready_pre_o), 32'b0001);
    tick();
    drain();
    chk("drop_count", 32'(log_id.size()), 32'd3);
    if (log_id.size() == 3) begin
      chk("drop_id0", 32'(log_id[0]), 32'd1);
      chk("drop_id1", 32'(log_id[1]), 32'd3);
      chk("drop_id2", 32'(log_id[2]), 32'd0);
    end

    // reset in the middle of traffic
    vld = '1;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("mrst_valid", 32'(valid_post_o), 32'd0);
      chk("mrst_id", 32'(id_post_o), 32'd0);
      chk("mrst_ready", 32'(ready_pre_o), 32'd0);
      tick();
    end
    rst = 1'b0;
    vld = 4'b0110;
    @(negedge clk);
    chk("mrst_first", 32'(ready_pre_o), 32'b0010);
    tick();
    vld = '0;
    @(negedge clk);
    chk("mrst_out_id", 32'(id_post_o), 32'd1);
    chk("mrst_out_v", 32'(valid_post_o), 32'd1);
    drain();

    // random soak
    clear_log();
    for (int k = 0; k < N; k++) begin
      src[k] = 1;
      waitc[k] = 0;
      exp_next[k] = 1;
    end
    soak_on = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      logic [N-1:0] acc;
      bit done;
      done = 1'b1;
      for (int k = 0; k < N; k++)
        if (exp_next[k] != SOAK_BEATS + 1) done = 1'b0;
      if (done) break;
      @(negedge clk);
      acc = vld & ready_pre_o;
      if (acc != '0) begin
        for (int k = 0; k < N; k++) begin
          if (acc[k]) begin
            chk("soak_wait", 32'(waitc[k] <= (N - 1) * MB), 32'd1);
            waitc[k] = 0;
          end else if (vld[k]) begin
            waitc[k]++;
          end
        end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k]) begin
          src[k]++;
          vld[k] = 1'b0;
        end
        if (!vld[k] && src[k] <= SOAK_BEATS)
          vld[k] = 1'($urandom_range(0, 1));
        dat[k*DW +: DW] = 8'(src[k]);
      end
      rdy = ($urandom_range(0, 3) != 0);
    end
    drain();
    soak_on = 1'b0;
    for (int k = 0; k < N; k++)
      chk("soak_total", 32'(exp_next[k]), 32'(SOAK_BEATS + 1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
